// File: rtl/md_sched.sv
// md_sched: multi-cycle MULT/DIV sequencer that owns HI/LO and raises the md-class stall.
// Optional abort path enabled by defining MD_CANCEL_EN.
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        md_use_d,
   input  logic        cancel,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        busy,
   output logic        stall_md
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_rs;
   logic [31:0] r_rt;
   logic [2:0]  r_op;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_busy;

   logic        w_cancel;
   logic        w_start_long;
   logic        w_op_div;

`ifdef MD_CANCEL_EN
   assign w_cancel = cancel;
`else
   logic w_unused_cancel;
   assign w_unused_cancel = cancel;
   assign w_cancel        = 1'b0;
`endif

   assign w_start_long = start & (md_op >= OP_MULT) & (md_op <= OP_DIVU);
   assign w_op_div     = (md_op == OP_DIV) | (md_op == OP_DIVU);
   assign stall_md     = md_use_d & (r_busy | w_start_long);

   assign hi_o = r_hi;
   assign lo_o = r_lo;
   assign busy = r_busy;

   // Products on the latched operands.
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   assign w_prod_s = $signed({{32{r_rs[31]}}, r_rs}) * $signed({{32{r_rt[31]}}, r_rt});
   assign w_prod_u = {32'd0, r_rs} * {32'd0, r_rt};

   // Division via magnitudes so the 0x80000000 / -1 case falls out without overflow.
   logic        w_signed;
   logic        w_rs_neg;
   logic        w_rt_neg;
   logic [31:0] w_rs_mag;
   logic [31:0] w_rt_mag;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   assign w_signed = (r_op == OP_DIV);
   assign w_rs_neg = w_signed & r_rs[31];
   assign w_rt_neg = w_signed & r_rt[31];
   assign w_rs_mag = w_rs_neg ? (32'd0 - r_rs) : r_rs;
   assign w_rt_mag = w_rt_neg ? (32'd0 - r_rt) : r_rt;
   assign w_q_mag  = w_rs_mag / w_rt_mag;
   assign w_r_mag  = w_rs_mag % w_rt_mag;
   assign w_quot   = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem    = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_rs    <= 32'd0;
         r_rt    <= 32'd0;
         r_op    <= 3'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start && !w_cancel) begin
                  if (w_start_long) begin
                     r_rs    <= rs_val;
                     r_rt    <= rt_val;
                     r_op    <= md_op;
                     r_cnt   <= w_op_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                  end else if (md_op == OP_MTHI) begin
                     r_hi <= rs_val;
                  end else if (md_op == OP_MTLO) begin
                     r_lo <= rs_val;
                  end
               end
            end
            RUN: begin
               if (w_cancel) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= 4'd0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
                  if (r_cnt == 4'd1) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     case (r_op)
                        OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                        OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                        OP_DIV, OP_DIVU: begin
                           // Divide by zero leaves HI/LO untouched.
                           if (r_rt != 32'd0) begin
                              r_lo <= w_quot;
                              r_hi <= w_rem;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the pipeline CPU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns the HI/LO registers.
- Sequences fixed-latency operations through a busy counter.
- Drives a stall request that holds any md-class instruction in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  E-stage instruction is md-class and valid this cycle.
- md_op  in  3  op code: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- md_use_d  in  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- cancel  in  1  abort the in-flight operation (see Optional Feature).
- hi_o  out  32  HI register.
- lo_o  out  32  LO register.
- busy  out  1  operation in flight.
- stall_md  out  1  stall request to the hazard unit.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n=0: hi_o=0, lo_o=0, busy=0, state IDLE, counter=0, operand latches=0. stall_md is combinational, so it reads md_use_d & start_long.
- start_long = start & (md_op in 1..4). stall_md = md_use_d & (busy | start_long), purely combinational.
- FSM with two states, IDLE and RUN.
- IDLE, start_long=1 at edge T:
  - latch rs_val, rt_val and md_op;
  - load cnt with MULT_CYCLES or DIV_CYCLES;
  - go to RUN; busy=1 from T.
- RUN: cnt decrements each edge.
  - At the edge where cnt goes 1→0: write HI/LO, clear busy, return to IDLE.
  - Busy is high for exactly N cycles. The result is visible on hi_o/lo_o in the first cycle with busy=0.
- Arithmetic, all on the latched operands:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: same as DIV, unsigned.
  - DIV 0x80000000 / -1: LO=0x80000000, HI=0.
- Divide by zero: runs the full DIV_CYCLES; HI and LO are left unchanged.
- MTHI/MTLO (start with md_op 5/6) in IDLE: write rs_val to HI or LO at the next edge. No busy, no stall contribution.
- start while busy=1: ignored, with no effect on state or HI/LO. The hazard unit guarantees this never occurs.
- start with md_op 0 or 7: ignored.
- Mid-operation rst_n low: abort immediately; all outputs go to reset values.
- Operands are captured only at start. Changes to rs_val/rt_val during RUN have no effect.

Optional Feature:
- Macro: MD_CANCEL_EN.
- Defined:
  - cancel=1 in RUN aborts at the next edge: busy=0, cnt=0, IDLE; HI/LO keep their pre-operation values.
  - cancel=1 in the same cycle as a start (any md_op 1..6) suppresses that start entirely.
  - cancel in IDLE with no start has no effect.
- Undefined: the cancel port still exists but is ignored; operations always complete.

Test Plan:
- MULT, rs=0xFFFFFFFE (-2), rt=3 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy=0.
- MULTU, rs=0xFFFFFFFF, rt=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV, rs=-7 (0xFFFFFFF9), rt=2 → busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with rt=0 → HI/LO unchanged after 10 cycles.
- Hold md_use_d=1 through a DIV → stall_md=1 in the start cycle and all 10 busy cycles, 0 afterwards. With md_use_d=0 → stall_md=0 throughout.
- MTLO rs=0x12345678 in IDLE → LO=0x12345678 next cycle, busy stays 0. A start of MULT issued while busy → HI/LO and the count are unaffected.
- Pull rst_n low at busy cycle 3 of a MULT → outputs 0 immediately, asynchronously. With MD_CANCEL_EN: cancel at busy cycle 4 of a DIV → busy=0 next cycle, HI/LO unchanged.
